sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge_if.sv | 70 +++++++
 rtl/sram_axi_bridge.sv | 132 +++++++++++++
 tb/tb_sram_axi_bridge.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side bundle for the SRAM-style core bridge: AR, R, AW, W and B channels.
// Every channel uses valid/ready: a beat transfers on the rising edge where both are high.
interface sram_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Single-outstanding bridge from a simple core request/response port to an AXI3 master.
// One single-beat INCR transaction per request; completion is a one-cycle resp_valid pulse.
module sram_axi_bridge #(
  parameter logic [3:0] ID = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_strb,
  output logic                req_ready,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  sram_axi_bridge_if.master   axi,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RADDR = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WADDR = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        aw_done;
  logic        w_done;
  logic        aw_done_n;
  logic        w_done_n;
  logic        unused_inputs;

  assign unused_inputs = ^{axi.rid, axi.rlast, axi.bid};

  assign req_ready   = (state == IDLE);
  assign dbg_state   = state;

  // Valids/readies are decoded from state and done flags so a reset clears them at once.
  assign axi.arvalid = (state == RADDR);
  assign axi.rready  = (state == RDATA);
  assign axi.awvalid = (state == WADDR) && !aw_done;
  assign axi.wvalid  = (state == WADDR) && !w_done;
  assign axi.bready  = (state == WRESP);

  assign aw_done_n   = aw_done || (axi.awvalid && axi.awready);
  assign w_done_n    = w_done  || (axi.wvalid  && axi.wready);

  assign axi.arid    = ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;

  assign axi.awid    = ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;

  assign axi.wid     = ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = strb_q;
  assign axi.wlast   = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= 32'h0;
      size_q     <= 2'b00;
      wdata_q    <= 32'h0;
      strb_q     <= 4'h0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            // An 8-byte request cannot exist on a 32-bit bus; issue it as a word.
            size_q  <= (req_size == 2'd3) ? 2'd2 : req_size;
            wdata_q <= req_wdata;
            strb_q  <= req_strb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= req_write ? WADDR : RADDR;
          end
        end
        RADDR: begin
          if (axi.arready) state <= RDATA;
        end
        RDATA: begin
          if (axi.rvalid) begin
            resp_rdata <= axi.rdata;
            resp_err   <= (axi.rresp != 2'b00);
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        WADDR: begin
          aw_done <= aw_done_n;
          w_done  <= w_done_n;
          if (aw_done_n && w_done_n) state <= WRESP;
        end
        WRESP: begin
          if (axi.bvalid) begin
            resp_err   <= (axi.bresp != 2'b00);
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed timing scenarios plus randomized traffic against a
// bench-side memory model; inputs driven and outputs sampled on the falling clock edge.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] slv_mem [0:255];

  sram_axi_bridge_if axi ();

  sram_axi_bridge #(.ID(4'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic slave_idle();
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    axi.rid = 4'h0; axi.rlast = 1'b1; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'h0;
  endtask

  task automatic req_read(input logic [31:0] a, input logic [1:0] sz);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_size = sz;
    req_wdata = $urandom; req_strb = 4'($urandom);
  endtask

  task automatic req_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_size = 2'd2;
    req_wdata = d; req_strb = s;
  endtask

  // Runs one request with a reactive slave: random waits, memory-backed reads, error region 0xE.
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int arw, input int aww, input int ww, input int rw, input int bw,
                        output logic rdy0, output logic resp0, output logic done,
                        output logic [31:0] rd, output logic er,
                        output logic [31:0] o_addr, output logic [2:0] o_size,
                        output logic [31:0] o_wdata, output logic [3:0] o_strb);
    logic ar_f, aw_f, w_f, r_f, b_f, ar_d, aw_d, w_d, r_d, b_d;
    int ar_c, aw_c, w_c, r_c, b_c;
    ar_f = 0; aw_f = 0; w_f = 0; r_f = 0; b_f = 0;
    ar_d = 0; aw_d = 0; w_d = 0; r_d = 0; b_d = 0;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    done = 0; rd = 32'h0; er = 0; o_addr = 32'h0; o_size = 3'h0; o_wdata = 32'h0; o_strb = 4'h0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = d; req_strb = s;
    rdy0 = req_ready;
    tick();
    resp0 = resp_valid;
    for (int c = 0; c < 200; c++) begin
      if (ar_f) ar_d = 1; if (aw_f) aw_d = 1; if (w_f) w_d = 1; if (r_f) r_d = 1; if (b_f) b_d = 1;
      if (resp_valid) begin
        done = 1; rd = resp_rdata; er = resp_err;
        break;
      end
      req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
      req_size = 2'($urandom); req_wdata = $urandom; req_strb = 4'($urandom);
      axi.arready = axi.arvalid && (ar_c >= arw);
      if (axi.arvalid && !axi.arready) ar_c++;
      ar_f = axi.arvalid && axi.arready;
      if (ar_f) begin o_addr = axi.araddr; o_size = axi.arsize; end
      axi.rvalid = ar_d && !r_d && (r_c >= rw);
      if (ar_d && !r_d && !axi.rvalid) r_c++;
      if (axi.rvalid) begin
        axi.rresp = (o_addr[31:28] == 4'hE) ? 2'b10 : 2'b00;
        axi.rdata = (o_addr[31:28] == 4'hE) ? 32'hBAD00000 : slv_mem[o_addr[9:2]];
      end
      r_f = axi.rvalid && axi.rready;
      axi.awready = axi.awvalid && (aw_c >= aww);
      if (axi.awvalid && !axi.awready) aw_c++;
      aw_f = axi.awvalid && axi.awready;
      if (aw_f) begin o_addr = axi.awaddr; o_size = axi.awsize; end
      axi.wready = axi.wvalid && (w_c >= ww);
      if (axi.wvalid && !axi.wready) w_c++;
      w_f = axi.wvalid && axi.wready;
      if (w_f) begin o_wdata = axi.wdata; o_strb = axi.wstrb; end
      axi.bvalid = aw_d && w_d && !b_d && (b_c >= bw);
      if (aw_d && w_d && !b_d && !axi.bvalid) b_c++;
      axi.bresp = (o_addr[31:28] == 4'hE) ? 2'b10 : 2'b00;
      b_f = axi.bvalid && axi.bready;
      if (b_f && o_addr[31:28] != 4'hE)
        for (int b = 0; b < 4; b++)
          if (o_strb[b]) slv_mem[o_addr[9:2]][8*b +: 8] = o_wdata[8*b +: 8];
      tick();
    end
    req_valid = 1'b0;
    slave_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_strb = 4'h0;
    slave_idle();
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
      n_err++; $display("FAIL reset_axi_valids: got %b want 00000",
        {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); end
    n_cmp++; if ({resp_valid, resp_err} !== 2'b00) begin n_err++; $display("FAIL reset_resp: got %b want 00", {resp_valid, resp_err}); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if ({axi.arlen, axi.arburst, axi.awburst, axi.wlast, axi.arid, axi.awid, axi.wid} !== {4'h0, 2'b01, 2'b01, 1'b1, 12'h0}) begin
      n_err++; $display("FAIL reset_constants: got %h", {axi.arlen, axi.arburst, axi.awburst, axi.wlast, axi.arid, axi.awid, axi.wid}); end
    n_cmp++; if ({axi.arlock, axi.awlock, axi.arcache, axi.awcache, axi.arprot, axi.awprot} !== 18'h0) begin
      n_err++; $display("FAIL reset_attr: got %h want 0", {axi.arlock, axi.awlock, axi.arcache, axi.awcache, axi.arprot, axi.awprot}); end
    tick(); tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_held_ready: got %b want 1", req_ready); end
    rst = 1'b0;
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_read_zero_wait();
    req_read(32'h1FC00000, 2'd2);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rd_accept: got %b want 1", req_ready); end
    axi.arready = 1'b1;
    tick(); req_valid = 1'b0;
    n_cmp++; if ({axi.arvalid, axi.araddr, axi.arsize} !== {1'b1, 32'h1FC00000, 3'b010}) begin
      n_err++; $display("FAIL rd_ar_t1: got %b %h %b want 1 1fc00000 010", axi.arvalid, axi.araddr, axi.arsize); end
    tick();
    n_cmp++; if ({axi.arvalid, axi.rready} !== 2'b01) begin n_err++; $display("FAIL rd_t2: got arvalid/rready %b want 01", {axi.arvalid, axi.rready}); end
    axi.rvalid = 1'b1; axi.rdata = 32'h3C1DBFC0; axi.rresp = 2'b00;
    tick(); slave_idle();
    n_cmp++; if ({resp_valid, resp_err, req_ready} !== 3'b101) begin n_err++; $display("FAIL rd_t3_flags: got %b want 101", {resp_valid, resp_err, req_ready}); end
    n_cmp++; if (resp_rdata !== 32'h3C1DBFC0) begin n_err++; $display("FAIL rd_t3_data: got %h want 3c1dbfc0", resp_rdata); end
    tick();
    n_cmp++; if ({resp_valid, resp_rdata} !== {1'b0, 32'h3C1DBFC0}) begin n_err++; $display("FAIL rd_t4_pulse: got %b %h", resp_valid, resp_rdata); end
  endtask

  task automatic test_write_skewed();
    req_wr(32'h80001000, 32'hDEADBEEF, 4'b0011);
    tick(); req_valid = 1'b0;
    n_cmp++; if ({axi.awvalid, axi.wvalid} !== 2'b11) begin n_err++; $display("FAIL wsk_t1_valids: got %b want 11", {axi.awvalid, axi.wvalid}); end
    n_cmp++; if ({axi.awaddr, axi.wdata, axi.wstrb, axi.awsize} !== {32'h80001000, 32'hDEADBEEF, 4'b0011, 3'b010}) begin
      n_err++; $display("FAIL wsk_t1_payload: got %h %h %b %b", axi.awaddr, axi.wdata, axi.wstrb, axi.awsize); end
    axi.wready = 1'b1;
    tick(); axi.wready = 1'b0;
    n_cmp++; if ({axi.awvalid, axi.wvalid} !== 2'b10) begin n_err++; $display("FAIL wsk_t2_valids: got %b want 10", {axi.awvalid, axi.wvalid}); end
    tick();
    n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin n_err++; $display("FAIL wsk_t3: got %b want 100", {axi.awvalid, axi.wvalid, axi.bready}); end
    tick();
    n_cmp++; if ({axi.awvalid, axi.awaddr} !== {1'b1, 32'h80001000}) begin n_err++; $display("FAIL wsk_t4_aw: got %b %h", axi.awvalid, axi.awaddr); end
    axi.awready = 1'b1;
    tick(); axi.awready = 1'b0;
    n_cmp++; if ({axi.awvalid, axi.bready, resp_valid} !== 3'b010) begin n_err++; $display("FAIL wsk_t5: got %b want 010", {axi.awvalid, axi.bready, resp_valid}); end
    tick();
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    tick(); slave_idle();
    n_cmp++; if ({resp_valid, resp_err, req_ready} !== 3'b101) begin n_err++; $display("FAIL wsk_resp: got %b want 101", {resp_valid, resp_err, req_ready}); end
    n_cmp++; if (resp_rdata !== 32'h3C1DBFC0) begin n_err++; $display("FAIL wsk_rdata_hold: got %h want 3c1dbfc0", resp_rdata); end
  endtask

  task automatic test_write_simul();
    req_wr(32'h00000010, 32'h12345678, 4'hF);
    tick(); req_valid = 1'b0;
    n_cmp++; if ({axi.awvalid, axi.wvalid} !== 2'b11) begin n_err++; $display("FAIL wsim_t1: got %b want 11", {axi.awvalid, axi.wvalid}); end
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick(); axi.awready = 1'b0; axi.wready = 1'b0;
    n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin n_err++; $display("FAIL wsim_t2_wresp: got %b want 001", {axi.awvalid, axi.wvalid, axi.bready}); end
    axi.bvalid = 1'b1; axi.bresp = 2'b10;
    tick(); slave_idle();
    n_cmp++; if ({resp_valid, resp_err} !== 2'b11) begin n_err++; $display("FAIL wsim_err_pulse: got %b want 11", {resp_valid, resp_err}); end
    tick();
    n_cmp++; if ({resp_valid, resp_err, axi.bready} !== 3'b010) begin n_err++; $display("FAIL wsim_err_hold: got %b want 010", {resp_valid, resp_err, axi.bready}); end
  endtask

  task automatic test_back_to_back();
    req_read(32'h00000100, 2'd2);
    axi.arready = 1'b1;
    tick(); req_valid = 1'b0;
    tick(); axi.rvalid = 1'b1; axi.rdata = 32'hAAAA0001;
    tick(); axi.rvalid = 1'b0;
    n_cmp++; if ({resp_valid, req_ready, resp_rdata} !== {2'b11, 32'hAAAA0001}) begin
      n_err++; $display("FAIL b2b_first: got %b %b %h", resp_valid, req_ready, resp_rdata); end
    req_read(32'h00000204, 2'd1);
    tick(); req_valid = 1'b0;
    n_cmp++; if ({axi.arvalid, axi.araddr, axi.arsize, resp_valid} !== {1'b1, 32'h00000204, 3'b001, 1'b0}) begin
      n_err++; $display("FAIL b2b_second_ar: got %b %h %b %b", axi.arvalid, axi.araddr, axi.arsize, resp_valid); end
    tick(); axi.rvalid = 1'b1; axi.rdata = 32'hBBBB0002;
    tick(); slave_idle();
    n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'hBBBB0002}) begin
      n_err++; $display("FAIL b2b_second_resp: got %b %b %h", resp_valid, resp_err, resp_rdata); end
  endtask

  task automatic test_backpressure();
    req_read(32'h00004444, 2'd3);
    tick();
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = $urandom; req_size = 2'($urandom);
      n_cmp++; if ({axi.arvalid, axi.araddr, axi.arsize, req_ready} !== {1'b1, 32'h00004444, 3'b010, 1'b0}) begin
        n_err++; $display("FAIL bp_stable[%0d]: got %b %h %b %b", i, axi.arvalid, axi.araddr, axi.arsize, req_ready); end
      tick();
    end
    req_valid = 1'b0; axi.arready = 1'b1;
    n_cmp++; if (axi.araddr !== 32'h00004444) begin n_err++; $display("FAIL bp_final_addr: got %h want 00004444", axi.araddr); end
    tick(); axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h5555AAAA;
    tick(); slave_idle();
    n_cmp++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h5555AAAA}) begin n_err++; $display("FAIL bp_resp: got %b %h", resp_valid, resp_rdata); end
    tick();
    n_cmp++; if ({axi.awvalid, axi.arvalid, req_ready} !== 3'b001) begin n_err++; $display("FAIL bp_no_ghost: got %b want 001", {axi.awvalid, axi.arvalid, req_ready}); end
  endtask

  task automatic test_reset_mid();
    req_read(32'h00000300, 2'd2);
    axi.arready = 1'b1;
    tick(); req_valid = 1'b0;
    tick(); axi.arready = 1'b0;
    n_cmp++; if (axi.rready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_rdata: got rready %b want 1", axi.rready); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({axi.arvalid, axi.rready, resp_valid, req_ready} !== 4'b0001) begin
      n_err++; $display("FAIL rstmid_async: got %b want 0001", {axi.arvalid, axi.rready, resp_valid, req_ready}); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_rdata_clear: got %h want 0", resp_rdata); end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL rstmid_after[%0d]: got %b want 01", i, {resp_valid, req_ready}); end
    end
  endtask

  task automatic test_random();
    logic wr, rdy0, resp0, done, er, exp_er;
    logic [1:0] sz;
    logic [2:0] exp_sz, o_size;
    logic [31:0] a, d, rd, o_addr, o_wdata, exp_rd, last_rd;
    logic [3:0] s, o_strb;
    last_rd = resp_rdata;
    for (int t = 0; t < 80; t++) begin
      wr = 1'($urandom);
      sz = 2'($urandom);
      a  = {($urandom_range(0, 3) == 0) ? 4'hE : 4'h0, 18'($urandom), 8'($urandom_range(0, 15)), 2'($urandom)};
      d  = $urandom;
      s  = 4'($urandom);
      exp_sz = (sz == 2'd3) ? 3'b010 : {1'b0, sz};
      exp_er = (a[31:28] == 4'hE);
      if (!wr) exp_q.push_back(exp_er ? 32'hBAD00000 : ref_mem[a[9:2]]);
      do_txn(wr, sz, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3),
             rdy0, resp0, done, rd, er, o_addr, o_size, o_wdata, o_strb);
      n_cmp++; if ({rdy0, resp0, done} !== 3'b101) begin n_err++; $display("FAIL rnd_flow[%0d]: ready/resp0/done got %b want 101", t, {rdy0, resp0, done}); end
      n_cmp++; if ({o_addr, o_size} !== {a, exp_sz}) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h %b want %h %b", t, o_addr, o_size, a, exp_sz); end
      n_cmp++; if (er !== exp_er) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want %b", t, er, exp_er); end
      if (wr) begin
        n_cmp++; if ({o_wdata, o_strb} !== {d, s}) begin n_err++; $display("FAIL rnd_wdata[%0d]: got %h %b want %h %b", t, o_wdata, o_strb, d, s); end
        n_cmp++; if (rd !== last_rd) begin n_err++; $display("FAIL rnd_rdata_hold[%0d]: got %h want %h", t, rd, last_rd); end
        if (!exp_er)
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_rd = exp_q.pop_front();
        n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", t, rd, exp_rd); end
        last_rd = exp_rd;
      end
      if ($urandom_range(0, 2) == 0) tick();
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    test_reset();
    test_read_zero_wait();
    test_write_skewed();
    test_write_simul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
